alarm_sequencer: RTL

Clocked arm/disarm controller for the home alarm. It turns raw keypad lines (k0..k4) and zone sensors (m1, m2 motion; r door reed) into a timed security state machine with exit delay, entry delay and a bounded siren. It replaces the combinational keypad-to-alarm decode: one-hot code 5'b00001 arms and 5'b00100 disarms. It drives `active`/`alarm` plus siren and status outputs toward the Arduino-side indicator logic.

---
 rtl/alarm_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/alarm_sequencer.sv
// Home alarm arm/disarm controller: synchronised keypad and zone inputs drive
// a timed DISARMED/EXIT/ARMED/ENTRY/ALARM machine with registered outputs.
module alarm_sequencer #(
  parameter int EXIT_CYCLES  = 8,
  parameter int ENTRY_CYCLES = 6,
  parameter int SIREN_CYCLES = 10,
  parameter int TW           = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       k0,
  input  logic       k1,
  input  logic       k2,
  input  logic       k3,
  input  logic       k4,
  input  logic       m1,
  input  logic       m2,
  input  logic       r,
  output logic       active,
  output logic       alarm,
  output logic       siren,
  output logic       exit_pending,
  output logic       entry_pending,
  output logic [2:0] cause,
  output logic       bad_key
);

  typedef enum logic [2:0] {
    S_DISARMED,
    S_EXIT,
    S_ARMED,
    S_ENTRY,
    S_ALARM
  } state_t;

  localparam logic [TW-1:0] EXIT_LOAD  = TW'(EXIT_CYCLES - 1);
  localparam logic [TW-1:0] ENTRY_LOAD = TW'(ENTRY_CYCLES - 1);
  localparam logic [TW-1:0] SIREN_LOAD = TW'(SIREN_CYCLES - 1);

  localparam logic [4:0] CODE_ARM    = 5'b00001;
  localparam logic [4:0] CODE_DISARM = 5'b00100;

  logic [7:0] raw;
  logic [7:0] sync1;
  logic [7:0] sync2;
  logic [4:0] ks;
  logic [4:0] ks_d;
  logic       m1s;
  logic       m2s;
  logic       rs;

  logic       key_ev;
  logic       arm_ev;
  logic       disarm_ev;
  logic       bad_ev;

  state_t        state;
  state_t        state_nx;
  logic [TW-1:0] tmr;
  logic [TW-1:0] tmr_nx;
  logic [2:0]    cause_nx;
  logic          siren_nx;

  assign raw = {k0, k1, k2, k3, k4, r, m2, m1};
  assign ks  = sync2[7:3];
  assign rs  = sync2[2];
  assign m2s = sync2[1];
  assign m1s = sync2[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      ks_d  <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      ks_d  <= ks;
    end
  end

  // A key event is the 0 -> nonzero edge of the code; code-to-code changes are silent.
  assign key_ev    = (ks != 5'b0) && (ks_d == 5'b0);
  assign arm_ev    = key_ev && (ks == CODE_ARM);
  assign disarm_ev = key_ev && (ks == CODE_DISARM);
  assign bad_ev    = key_ev && (ks != CODE_ARM) && (ks != CODE_DISARM);

  always_comb begin
    state_nx = state;
    tmr_nx   = tmr;
    cause_nx = cause;
    case (state)
      S_DISARMED: begin
        if (arm_ev) begin
          state_nx = S_EXIT;
          tmr_nx   = EXIT_LOAD;
        end
      end
      S_EXIT: begin
        if (disarm_ev) begin
          state_nx = S_DISARMED;
        end else if (tmr == '0) begin
          state_nx = S_ARMED;
        end else begin
          tmr_nx = tmr - 1'b1;
        end
      end
      S_ARMED: begin
        if (disarm_ev) begin
          state_nx = S_DISARMED;
        end else if (m1s || m2s) begin
          state_nx = S_ALARM;
          cause_nx = {1'b0, m2s, m1s};
          tmr_nx   = SIREN_LOAD;
        end else if (rs) begin
          state_nx = S_ENTRY;
          cause_nx = 3'b100;
          tmr_nx   = ENTRY_LOAD;
        end
      end
      S_ENTRY: begin
        if (disarm_ev) begin
          state_nx = S_DISARMED;
        end else if (tmr == '0) begin
          state_nx = S_ALARM;
          tmr_nx   = SIREN_LOAD;
        end else begin
          tmr_nx = tmr - 1'b1;
        end
      end
      S_ALARM: begin
        if (disarm_ev) begin
          state_nx = S_DISARMED;
        end else if (tmr != '0) begin
          tmr_nx = tmr - 1'b1;
        end
      end
      default: begin
        state_nx = S_DISARMED;
        tmr_nx   = '0;
      end
    endcase
    if (state_nx == S_DISARMED) begin
      cause_nx = 3'b000;
      tmr_nx   = '0;
    end
  end

  // Siren covers the entry cycle plus every ALARM cycle whose timer was still nonzero.
  assign siren_nx = (state_nx == S_ALARM) && ((state != S_ALARM) || (tmr != '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_DISARMED;
      tmr           <= '0;
      cause         <= 3'b000;
      active        <= 1'b0;
      alarm         <= 1'b0;
      siren         <= 1'b0;
      exit_pending  <= 1'b0;
      entry_pending <= 1'b0;
      bad_key       <= 1'b0;
    end else begin
      state         <= state_nx;
      tmr           <= tmr_nx;
      cause         <= cause_nx;
      active        <= (state_nx != S_DISARMED);
      alarm         <= (state_nx == S_ALARM);
      siren         <= siren_nx;
      exit_pending  <= (state_nx == S_EXIT);
      entry_pending <= (state_nx == S_ENTRY);
      bad_key       <= bad_ev;
    end
  end

endmodule
